// File: rtl/systolic_mm_if.sv
// rtl/systolic_mm_if.sv - operand beat / result handshake bundle for systolic_mm
interface systolic_mm_if #(
  parameter int N    = 4,
  parameter int DW   = 16,
  parameter int ACCW = 2*DW + $clog2(N)
);
  logic                  in_valid;
  logic                  in_ready;
  logic                  acc_en;
  logic [N*DW-1:0]       a_col;
  logic [N*DW-1:0]       b_row;
  logic                  out_valid;
  logic                  out_ready;
  logic [N*N*ACCW-1:0]   c_out;
  logic                  busy;

  modport master (
    output in_valid, acc_en, a_col, b_row, out_ready,
    input  in_ready, out_valid, c_out, busy
  );

  modport slave (
    input  in_valid, acc_en, a_col, b_row, out_ready,
    output in_ready, out_valid, c_out, busy
  );
endinterface

// File: rtl/systolic_mm.sv
// rtl/systolic_mm.sv - output-stationary N x N systolic matrix multiplier
// One K-step per accepted beat; N beats per job, result valid 2N-1 cycles after the last beat.
module systolic_mm #(
  parameter int N    = 4,
  parameter int DW   = 16,
  parameter int ACCW = 2*DW + $clog2(N)
) (
  input  logic          clk,
  input  logic          reset,
  systolic_mm_if.slave  bus
);
  localparam int CW = $clog2(2*N);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [CW-1:0]          cnt;
  logic                   accept;
  logic                   clear;

  logic signed [DW-1:0]   a_sk   [N][N];
  logic signed [DW-1:0]   b_sk   [N][N];
  logic signed [DW-1:0]   a_pe   [N][N];
  logic signed [DW-1:0]   b_pe   [N][N];
  logic signed [DW-1:0]   a_left [N][N];
  logic signed [DW-1:0]   b_up   [N][N];
  logic signed [2*DW-1:0] prod   [N][N];
  logic signed [ACCW-1:0] acc    [N][N];

  assign accept = bus.in_valid && bus.in_ready;
  assign clear  = accept && (state == IDLE) && !bus.acc_en;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = LOAD;
      LOAD:    if (accept && cnt == CW'(N-1)) state_nxt = DRAIN;
      DRAIN:   if (cnt == CW'(2*N-2)) state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state == IDLE) || (state == LOAD);
    bus.out_valid = (state == DONE);
    bus.busy      = (state != IDLE);
  end

  // Counts beats in IDLE/LOAD, then reuses the same register as the drain timer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else begin
      case (state)
        IDLE:    if (accept) cnt <= CW'(1);
        LOAD:    if (accept) cnt <= (cnt == CW'(N-1)) ? '0 : cnt + CW'(1);
        DRAIN:   cnt <= cnt + CW'(1);
        default: cnt <= '0;
      endcase
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      if (j == 0) begin : g_a_edge
        assign a_left[i][j] = a_sk[i][i];
      end else begin : g_a_inner
        assign a_left[i][j] = a_pe[i][j-1];
      end
      if (i == 0) begin : g_b_edge
        assign b_up[i][j] = b_sk[j][j];
      end else begin : g_b_inner
        assign b_up[i][j] = b_pe[i-1][j];
      end
      assign prod[i][j] = (2*DW)'(a_left[i][j]) * (2*DW)'(b_up[i][j]);
    end
  end

  // Non-accepting cycles push zeros so bubbles and the drain contribute nothing
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          a_sk[i][j] <= '0;
          b_sk[i][j] <= '0;
          a_pe[i][j] <= '0;
          b_pe[i][j] <= '0;
          acc[i][j]  <= '0;
        end
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        a_sk[i][0] <= accept ? bus.a_col[i*DW +: DW] : '0;
        b_sk[i][0] <= accept ? bus.b_row[i*DW +: DW] : '0;
        for (int d = 1; d < N; d++) begin
          a_sk[i][d] <= a_sk[i][d-1];
          b_sk[i][d] <= b_sk[i][d-1];
        end
        for (int j = 0; j < N; j++) begin
          a_pe[i][j] <= a_left[i][j];
          b_pe[i][j] <= b_up[i][j];
          acc[i][j]  <= clear ? '0 : acc[i][j] + ACCW'(prod[i][j]);
        end
      end
    end
  end

  always_comb begin
    bus.c_out = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        bus.c_out[(i*N+j)*ACCW +: ACCW] = acc[i][j];
      end
    end
  end
endmodule

// File: tb/tb_systolic_mm.sv
// tb/tb_systolic_mm.sv - directed self-checking bench for systolic_mm (N=2, DW=16)
module tb_systolic_mm;
  localparam int N    = 2;
  localparam int DW   = 16;
  localparam int ACCW = 33;

  localparam logic [N*N*ACCW-1:0] C_BASE = {33'd50, 33'd43, 33'd22, 33'd19};
  localparam logic [N*N*ACCW-1:0] C_ACC  = {33'd100, 33'd86, 33'd44, 33'd38};
  localparam logic [N*N*ACCW-1:0] C_NEG  = {4{33'h080000000}};

  logic clk   = 1'b0;
  logic reset = 1'b1;

  systolic_mm_if #(.N(N), .DW(DW), .ACCW(ACCW)) bus();
  systolic_mm #(.N(N), .DW(DW), .ACCW(ACCW)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int am [2][2];
  int bm [2][2];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_basic();
    am = '{'{1, 2}, '{3, 4}};
    bm = '{'{5, 6}, '{7, 8}};
  endtask

  task automatic drive_beat(input int k, input bit acc);
    bus.in_valid = 1'b1;
    bus.acc_en   = acc;
    bus.a_col    = {16'(am[1][k]), 16'(am[0][k])};
    bus.b_row    = {16'(bm[k][1]), 16'(bm[k][0])};
  endtask

  // beat 2 carries the opposite acc_en, which the block must ignore
  task automatic send_beats(input bit acc, input int gap);
    drive_beat(0, acc);
    tick();
    bus.in_valid = 1'b0;
    repeat (gap) tick();
    drive_beat(1, !acc);
    tick();
    bus.in_valid = 1'b0;
    bus.acc_en   = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic ack();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0; bus.acc_en = 1'b0; bus.out_ready = 1'b0;
    bus.a_col = '0; bus.b_row = '0;
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.c_out !== '0) begin errors++; $display("FAIL reset_c_out: got %h expected 0", bus.c_out); end
  endtask

  task automatic test_basic();
    int lat;
    load_basic();
    send_beats(1'b0, 0);
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL basic_drain_ready: got %b expected 0", bus.in_ready); end
    wait_done(lat);
    checks++; if (lat !== 3) begin errors++; $display("FAIL basic_latency: got %0d expected 3", lat); end
    checks++; if (bus.c_out !== C_BASE) begin errors++; $display("FAIL basic_c_out: got %h expected %h", bus.c_out, C_BASE); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL basic_busy_done: got %b expected 1", bus.busy); end
    ack();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL basic_out_valid_after_ack: got %b expected 0", bus.out_valid); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL basic_busy_idle: got %b expected 0", bus.busy); end
    repeat (2) tick();
    checks++; if (bus.c_out !== C_BASE) begin errors++; $display("FAIL basic_c_out_hold: got %h expected %h", bus.c_out, C_BASE); end
  endtask

  task automatic test_accumulate();
    int lat;
    load_basic();
    send_beats(1'b1, 0);
    wait_done(lat);
    checks++; if (lat !== 3) begin errors++; $display("FAIL acc_latency: got %0d expected 3", lat); end
    checks++; if (bus.c_out !== C_ACC) begin errors++; $display("FAIL acc_c_out: got %h expected %h", bus.c_out, C_ACC); end
    ack();
  endtask

  task automatic test_bubbles();
    int lat;
    load_basic();
    send_beats(1'b0, 3);
    wait_done(lat);
    checks++; if (lat !== 3) begin errors++; $display("FAIL bubble_latency: got %0d expected 3", lat); end
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bubble_hold_valid[%0d]: got %b expected 1", c, bus.out_valid); end
      checks++; if (bus.c_out !== C_BASE) begin errors++; $display("FAIL bubble_hold_c_out[%0d]: got %h expected %h", c, bus.c_out, C_BASE); end
    end
    ack();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bubble_ack: got %b expected 0", bus.out_valid); end
  endtask

  task automatic test_extreme();
    int lat;
    am = '{'{-32768, -32768}, '{-32768, -32768}};
    bm = '{'{-32768, -32768}, '{-32768, -32768}};
    send_beats(1'b0, 0);
    wait_done(lat);
    checks++; if (bus.c_out !== C_NEG) begin errors++; $display("FAIL extreme_c_out: got %h expected %h", bus.c_out, C_NEG); end
    ack();
  endtask

  task automatic test_reset_abort();
    int lat;
    load_basic();
    drive_beat(0, 1'b0);
    tick();
    bus.in_valid = 1'b0;
    tick();
    reset = 1'b1;
    #2;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort_async_busy: got %b expected 0", bus.busy); end
    tick();
    reset = 1'b0;
    tick();
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL abort_in_ready: got %b expected 1", bus.in_ready); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL abort_out_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.c_out !== '0) begin errors++; $display("FAIL abort_c_out: got %h expected 0", bus.c_out); end
    send_beats(1'b0, 0);
    wait_done(lat);
    checks++; if (lat !== 3) begin errors++; $display("FAIL abort_rerun_latency: got %0d expected 3", lat); end
    checks++; if (bus.c_out !== C_BASE) begin errors++; $display("FAIL abort_rerun_c_out: got %h expected %h", bus.c_out, C_BASE); end
    ack();
  endtask

  task automatic test_drain_ignore();
    int lat;
    load_basic();
    send_beats(1'b0, 0);
    bus.in_valid = 1'b1;
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL ignore_drain_ready[%0d]: got %b expected 0", lat, bus.in_ready); end
      bus.a_col = $urandom;
      bus.b_row = $urandom;
      bus.acc_en = 1'($urandom);
      tick();
      lat++;
    end
    checks++; if (lat !== 3) begin errors++; $display("FAIL ignore_latency: got %0d expected 3", lat); end
    for (int c = 0; c < 2; c++) begin
      bus.a_col = $urandom;
      bus.b_row = $urandom;
      tick();
      checks++; if (bus.c_out !== C_BASE) begin errors++; $display("FAIL ignore_done_c_out[%0d]: got %h expected %h", c, bus.c_out, C_BASE); end
    end
    bus.in_valid = 1'b0;
    ack();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL ignore_busy_after: got %b expected 0", bus.busy); end
    checks++; if (bus.c_out !== C_BASE) begin errors++; $display("FAIL ignore_c_out_after: got %h expected %h", bus.c_out, C_BASE); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_accumulate();
    test_bubbles();
    test_extreme();
    test_reset_abort();
    test_drain_ignore();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end
endmodule

// File: doc/systolic_mm.md
SYSTOLIC_MM -- requirements
Module: systolic_mm

Interface
REQ-001 SHALL have parameter N, default 4, array dimension (N x N output-stationary PEs, N >= 2).
REQ-002 SHALL have parameter DW, default 16, signed operand width.
REQ-003 SHALL have parameter ACCW, default 2*DW+$clog2(N), signed accumulator/result width.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 in_valid  input  1  beat k present on a_col/b_row.
REQ-007 in_ready  output  1  block accepts a beat this cycle.
REQ-008 acc_en  input  1  sampled with first beat: 1 = accumulate onto held C, 0 = clear first.
REQ-009 a_col  input  N*DW  column k of A; element i = A[i][k] at bits [i*DW +: DW].
REQ-010 b_row  input  N*DW  row k of B; element j = B[k][j] at bits [j*DW +: DW].
REQ-011 out_valid  output  1  c_out holds a complete result.
REQ-012 out_ready  input  1  consumer accepts result.
REQ-013 c_out  output  N*N*ACCW  C[i][j] at bits [(i*N+j)*ACCW +: ACCW].
REQ-014 busy  output  1  high in any state except IDLE.

Function
REQ-015 SHALL compute C = A*B (or C_prev + A*B when acc_en=1) for N x N signed matrices, one K-step per accepted beat, exactly N beats per job.
REQ-016 FSM SHALL have states IDLE, LOAD, DRAIN, DONE.
REQ-017 in_ready SHALL be 1 in IDLE and LOAD, 0 in DRAIN and DONE; beat accepted when in_valid && in_ready.
REQ-018 IDLE: accepted beat SHALL latch acc_en, clear all accumulators when acc_en=0, count beat 1, go LOAD (N-1 beats remain).
REQ-019 LOAD: on acceptance of the Nth beat SHALL go DRAIN; acc_en ignored on beats 2..N.
REQ-020 Input skew: A row i SHALL be delayed i cycles, B column j delayed j cycles, so that A[i][k] and B[k][j] meet at PE(i,j).
REQ-021 Cycles in LOAD with no accepted beat SHALL inject zeros into the skew chains; bubbles SHALL NOT change the result.
REQ-022 Each PE SHALL forward a right and b down one register per cycle and accumulate a*b every cycle (zeros contribute nothing).
REQ-023 DRAIN SHALL last exactly 2N-1 cycles; out_valid SHALL rise on edge E+2N-1, E = edge accepting beat N.
REQ-024 DONE: out_valid=1, c_out stable; on out_valid && out_ready SHALL go IDLE, out_valid=0 the next cycle.
REQ-025 c_out SHALL hold the last result through IDLE until the next job's first beat; accumulators hold across jobs (acc_en=1 tiling).
REQ-026 Arithmetic: DW x DW full-precision signed product, sign-extended to ACCW; accumulator SHALL wrap two's complement, no saturation.
REQ-027 out_ready while not in DONE SHALL be ignored; in_valid in DRAIN/DONE SHALL be ignored (not accepted, not buffered).
REQ-028 Output decode SHALL be same-cycle combinational from state (no extra latency on in_ready/out_valid).

Reset
REQ-029 reset SHALL asynchronously force IDLE, clear all skew, PE, accumulator and counter registers; c_out=0, out_valid=0, busy=0, in_ready=1 after release.
REQ-030 reset asserted mid-LOAD or mid-DRAIN SHALL abort the job; no partial result SHALL appear.

Verification (N=2, DW=16)
REQ-031 A=[[1,2],[3,4]], B=[[5,6],[7,8]], acc_en=0, back-to-back beats -> c_out=[[19,22],[43,50]], out_valid exactly 3 cycles after beat 2.
REQ-032 Same job again with acc_en=1 -> c_out=[[38,44],[86,100]].
REQ-033 Same job as REQ-031 with 3 idle cycles between beats, out_ready held 0 for 5 cycles in DONE -> [[19,22],[43,50]], out_valid and c_out stable until handshake.
REQ-034 All A, B elements = -32768 -> every C[i][j] = 2147483648 (ACCW=33, no wrap).
REQ-035 reset pulsed after beat 1 -> in_ready=1, busy=0, out_valid=0, c_out=0; fresh REQ-031 job then yields correct result.
REQ-036 in_valid held 1 throughout DRAIN/DONE with random data -> no extra beats accepted; result equals REQ-031 values.
